// File: rtl/uart_core.sv
// 8N1 UART: shared 16x baud tick, transmitter and receiver (tx is registered, so the line lags the FSM by 1 clk; rx adds 2 clk of sync latency).
// No backpressure: tx_start is only sampled in IDLE; received bytes are simply overwritten by the next frame.
module uart_core #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_TICKS = 16,
  parameter int DVSR_W     = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DVSR_W-1:0]    dvsr,
  output logic                 sample_tick,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] data_byte,
  output logic                 tx,
  output logic                 tx_done_tick,
  input  logic                 rx,
  output logic                 rx_done_tick,
  output logic [DATA_BITS-1:0] received_byte
);

  localparam int TCW = (STOP_TICKS > 16) ? $clog2(STOP_TICKS) : 4;
  localparam int NBW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TCW-1:0] TICK_MID  = TCW'(7);
  localparam logic [TCW-1:0] TICK_LAST = TCW'(15);
  localparam logic [TCW-1:0] STOP_LAST = TCW'(STOP_TICKS - 1);
  localparam logic [NBW-1:0] BIT_LAST  = NBW'(DATA_BITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  // ---------------- baud generator ----------------
  logic [DVSR_W-1:0] baud_cnt_q, baud_cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      baud_cnt_q <= '0;
    end else begin
      baud_cnt_q <= baud_cnt_d;
    end
  end

  // Wrapping on >= lets a shrinking dvsr take effect without a long run-out.
  always_comb begin
    baud_cnt_d = baud_cnt_q + DVSR_W'(1);
    if (baud_cnt_q >= dvsr) begin
      baud_cnt_d = '0;
    end
  end

  // Gating with reset keeps both done pulses quiet in the reset cycle.
  assign sample_tick = ~reset & (baud_cnt_q == dvsr);

  // ---------------- transmitter ----------------
  state_e                 tx_state_q, tx_state_d;
  logic [TCW-1:0]         tx_s_q, tx_s_d;
  logic [NBW-1:0]         tx_n_q, tx_n_d;
  logic [DATA_BITS-1:0]   tx_b_q, tx_b_d;
  logic                   tx_q, tx_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= S_IDLE;
      tx_s_q     <= '0;
      tx_n_q     <= '0;
      tx_b_q     <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_s_q     <= tx_s_d;
      tx_n_q     <= tx_n_d;
      tx_b_q     <= tx_b_d;
      tx_q       <= tx_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_s_d     = tx_s_q;
    tx_n_d     = tx_n_q;
    tx_b_d     = tx_b_q;
    case (tx_state_q)
      S_IDLE: begin
        if (tx_start) begin
          tx_state_d = S_START;
          tx_s_d     = '0;
          tx_b_d     = data_byte;
        end
      end
      S_START: begin
        if (sample_tick) begin
          if (tx_s_q == TICK_LAST) begin
            tx_state_d = S_DATA;
            tx_s_d     = '0;
            tx_n_d     = '0;
          end else begin
            tx_s_d = tx_s_q + TCW'(1);
          end
        end
      end
      S_DATA: begin
        if (sample_tick) begin
          if (tx_s_q == TICK_LAST) begin
            tx_s_d = '0;
            tx_b_d = tx_b_q >> 1;
            if (tx_n_q == BIT_LAST) begin
              tx_state_d = S_STOP;
            end else begin
              tx_n_d = tx_n_q + NBW'(1);
            end
          end else begin
            tx_s_d = tx_s_q + TCW'(1);
          end
        end
      end
      S_STOP: begin
        if (sample_tick) begin
          if (tx_s_q == STOP_LAST) begin
            tx_state_d = S_IDLE;
          end else begin
            tx_s_d = tx_s_q + TCW'(1);
          end
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_d         = 1'b1;
    tx_done_tick = 1'b0;
    case (tx_state_q)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = tx_b_q[0];
      S_STOP:  tx_done_tick = sample_tick && (tx_s_q == STOP_LAST);
      default: tx_d = 1'b1;
    endcase
  end

  assign tx = tx_q;

  // ---------------- receiver ----------------
  logic rx_meta_q, rx_sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  state_e                 rx_state_q, rx_state_d;
  logic [TCW-1:0]         rx_s_q, rx_s_d;
  logic [NBW-1:0]         rx_n_q, rx_n_d;
  logic [DATA_BITS-1:0]   rx_b_q, rx_b_d;
  logic [DATA_BITS-1:0]   rx_byte_q, rx_byte_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q <= S_IDLE;
      rx_s_q     <= '0;
      rx_n_q     <= '0;
      rx_b_q     <= '0;
      rx_byte_q  <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_s_q     <= rx_s_d;
      rx_n_q     <= rx_n_d;
      rx_b_q     <= rx_b_d;
      rx_byte_q  <= rx_byte_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_s_d     = rx_s_q;
    rx_n_d     = rx_n_q;
    rx_b_d     = rx_b_q;
    case (rx_state_q)
      S_IDLE: begin
        if (!rx_sync_q) begin
          rx_state_d = S_START;
          rx_s_d     = '0;
        end
      end
      S_START: begin
        if (sample_tick) begin
          if (rx_s_q == TICK_MID) begin
            // A start bit that is high again by mid-bit was only a glitch.
            rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
            rx_s_d     = '0;
            rx_n_d     = '0;
          end else begin
            rx_s_d = rx_s_q + TCW'(1);
          end
        end
      end
      S_DATA: begin
        if (sample_tick) begin
          if (rx_s_q == TICK_LAST) begin
            rx_s_d = '0;
            rx_b_d = {rx_sync_q, rx_b_q[DATA_BITS-1:1]};
            if (rx_n_q == BIT_LAST) begin
              rx_state_d = S_STOP;
            end else begin
              rx_n_d = rx_n_q + NBW'(1);
            end
          end else begin
            rx_s_d = rx_s_q + TCW'(1);
          end
        end
      end
      S_STOP: begin
        if (sample_tick) begin
          if (rx_s_q == STOP_LAST) begin
            rx_state_d = S_IDLE;
          end else begin
            rx_s_d = rx_s_q + TCW'(1);
          end
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rx_done_tick = 1'b0;
    rx_byte_d    = rx_byte_q;
    if (rx_state_q == S_STOP && sample_tick && rx_s_q == STOP_LAST) begin
      rx_done_tick = 1'b1;
      rx_byte_d    = rx_b_q;
    end
  end

  assign received_byte = rx_byte_q;

endmodule

// File: tb/tb_uart_core.sv
// Bench for uart_core: tick rates, idle line, loopback frames, busy-ignore, rx glitch and mid-frame reset.
module tb_uart_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] dvsr;
  logic        sample_tick;
  logic        tx_start;
  logic [7:0]  data_byte;
  logic        tx;
  logic        tx_done_tick;
  logic        rx;
  logic        rx_done_tick;
  logic [7:0]  received_byte;

  logic        loop_en;
  logic        rx_drv;

  assign rx = loop_en ? tx : rx_drv;

  always #5 clk = ~clk;

  uart_core #(.DATA_BITS(8), .STOP_TICKS(16), .DVSR_W(11)) dut (
    .clk           (clk),
    .reset         (reset),
    .dvsr          (dvsr),
    .sample_tick   (sample_tick),
    .tx_start      (tx_start),
    .data_byte     (data_byte),
    .tx            (tx),
    .tx_done_tick  (tx_done_tick),
    .rx            (rx),
    .rx_done_tick  (rx_done_tick),
    .received_byte (received_byte)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard of bytes expected at the receiver.
  logic [7:0] sb[$];

  int cyc         = 0;
  int tx_done_cnt = 0;
  int rx_done_cnt = 0;
  int tx_done_cyc = 0;
  logic tx_prev   = 1'b0;
  logic rx_prev   = 1'b0;
  logic rx_pend   = 1'b0;

  always @(posedge clk) cyc++;

  // received_byte updates on the edge closing the rx_done cycle, so compare one cycle later.
  always @(negedge clk) begin
    if (rx_pend) begin
      if (sb.size() == 0) begin
        chk("rx_unexpected_byte", 32'(sb.size()), 32'd1);
      end else begin
        chk("rx_byte", {24'd0, received_byte}, {24'd0, sb.pop_front()});
      end
    end
    rx_pend = rx_done_tick;
    if (rx_done_tick) begin
      chk("rx_done_1clk", {31'd0, rx_prev}, 32'd0);
      rx_done_cnt++;
    end
    if (tx_done_tick) begin
      chk("tx_done_1clk", {31'd0, tx_prev}, 32'd0);
      tx_done_cnt++;
      tx_done_cyc = cyc;
    end
    rx_prev = rx_done_tick;
    tx_prev = tx_done_tick;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic expect_rx, output int start_cyc);
    if (expect_rx) sb.push_back(b);
    data_byte = b;
    tx_start  = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    tx_start  = 1'b0;
  endtask

  task automatic wait_tx(input int target, input int budget, input string tag);
    for (int i = 0; i < budget && tx_done_cnt < target; i++) @(negedge clk);
    chk(tag, 32'(tx_done_cnt), 32'(target));
  endtask

  task automatic wait_rx(input int target, input int budget, input string tag);
    for (int i = 0; i < budget && rx_done_cnt < target; i++) @(negedge clk);
    chk(tag, 32'(rx_done_cnt), 32'(target));
  endtask

  task automatic count_ticks(input int n, output int ticks);
    ticks = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (sample_tick) ticks++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks;
    int t0;
    int lat;
    logic all_high;
    logic seen_low;
    logic [9:0] frame;

    reset     = 1'b1;
    dvsr      = 11'd2;
    tx_start  = 1'b0;
    data_byte = 8'h00;
    loop_en   = 1'b1;
    rx_drv    = 1'b1;
    step(5);

    chk("rst_sample_tick", {31'd0, sample_tick}, 32'd0);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_tx_done", {31'd0, tx_done_tick}, 32'd0);
    chk("rst_rx_done", {31'd0, rx_done_tick}, 32'd0);
    chk("rst_received_byte", {24'd0, received_byte}, 32'd0);
    reset = 1'b0;

    // Baud tick rates.
    step(3);
    count_ticks(30, ticks);
    chk("tick_dvsr2", 32'(ticks), 32'd10);
    dvsr = 11'd0;
    step(3);
    count_ticks(30, ticks);
    chk("tick_dvsr0", 32'(ticks), 32'd30);
    dvsr = 11'd5;
    step(8);
    count_ticks(60, ticks);
    chk("tick_dvsr5", 32'(ticks), 32'd10);
    dvsr = 11'd2;
    step(8);

    // Idle line.
    all_high = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) all_high = 1'b0;
    end
    chk("idle_tx_high", {31'd0, all_high}, 32'd1);
    chk("idle_tx_done_cnt", 32'(tx_done_cnt), 32'd0);
    chk("idle_rx_done_cnt", 32'(rx_done_cnt), 32'd0);
    chk("idle_received_byte", {24'd0, received_byte}, 32'd0);

    // Loopback 0x9E: sample each bit near its centre.
    send(8'h9E, 1'b1, t0);
    seen_low = 1'b0;
    for (int i = 0; i < 200 && !seen_low; i++) begin
      if (tx === 1'b0) seen_low = 1'b1;
      else @(negedge clk);
    end
    chk("frame_start_seen", {31'd0, seen_low}, 32'd1);
    step(24);
    frame[0] = tx;
    for (int i = 1; i < 10; i++) begin
      step(48);
      frame[i] = tx;
    end
    chk("frame_bits_9e", {22'd0, frame}, {22'd0, 1'b1, 8'h9E, 1'b0});
    wait_tx(1, 200, "loop_tx_done_cnt");
    wait_rx(1, 200, "loop_rx_done_cnt");
    lat = tx_done_cyc - t0;
    chk("tx_done_latency_480", {31'd0, (lat >= 470 && lat <= 490)}, 32'd1);
    step(2);
    chk("loop_received_byte", {24'd0, received_byte}, 32'h9E);

    // Busy ignore: second start with 0x55 lands mid-frame.
    step(10);
    send(8'h9E, 1'b1, t0);
    step(100);
    send(8'h55, 1'b0, t0);
    data_byte = 8'h55;
    wait_tx(2, 700, "busy_tx_done_cnt");
    step(600);
    chk("busy_tx_done_total", 32'(tx_done_cnt), 32'd2);
    chk("busy_rx_done_total", 32'(rx_done_cnt), 32'd2);
    chk("busy_sb_empty", 32'(sb.size()), 32'd0);
    chk("busy_received_byte", {24'd0, received_byte}, 32'h9E);

    // Glitch: rx low for 2 ticks only.
    loop_en = 1'b0;
    rx_drv  = 1'b0;
    step(6);
    rx_drv  = 1'b1;
    step(600);
    chk("glitch_rx_done_cnt", 32'(rx_done_cnt), 32'd2);
    chk("glitch_received_byte", {24'd0, received_byte}, 32'h9E);
    loop_en = 1'b1;
    step(5);

    // Reset during DATA aborts the frame silently.
    send(8'hC3, 1'b0, t0);
    step(150);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_tx_high", {31'd0, tx}, 32'd1);
    step(600);
    chk("midrst_tx_done_cnt", 32'(tx_done_cnt), 32'd2);
    chk("midrst_rx_done_cnt", 32'(rx_done_cnt), 32'd2);
    chk("midrst_received_byte", {24'd0, received_byte}, 32'd0);

    send(8'hA5, 1'b1, t0);
    wait_tx(3, 700, "post_rst_tx_done_cnt");
    wait_rx(3, 200, "post_rst_rx_done_cnt");
    step(2);
    chk("post_rst_received_byte", {24'd0, received_byte}, 32'hA5);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
